// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: UART receiver with glitch reject, mid-bit majority vote and one-byte holding register.
// Define UART_RX_PARITY_EN for 8E1 framing with parity checking; otherwise 8N1.
module uart_rx_deframer #(
   parameter int CLK_FREQ     = 25000000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_busy,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_parity_err
);
   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   if (CLKS_PER_BIT < 4) begin : g_bad_cfg
      $error("uart_rx_deframer: CLKS_PER_BIT must be >= 4");
   end
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE
`ifdef UART_RX_PARITY_EN
      , PARITY
`endif
   } state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [1:0]    hist;
   logic [7:0]    sh;
   logic          vote;
   logic          bit_end;
`ifdef UART_RX_PARITY_EN
   logic          par;
`endif
   // hist holds the two previous samples; the current i_rx completes the 3-sample window
   assign vote    = (i_rx & hist[0]) | (i_rx & hist[1]) | (hist[0] & hist[1]);
   assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
   assign o_busy  = state != IDLE;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         hist         <= 2'b11;
         sh           <= '0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_frame_err  <= 1'b0;
         o_overrun    <= 1'b0;
         o_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par          <= 1'b0;
`endif
      end else begin
         hist         <= {hist[0], i_rx};
         cnt          <= cnt + 1'b1;
         o_frame_err  <= 1'b0;
         o_overrun    <= 1'b0;
         o_parity_err <= 1'b0;
         if (o_valid && i_ready) o_valid <= 1'b0;
         case (state)
            IDLE: if (!i_rx) begin
               state <= START;
               cnt   <= '0;
            end
            START: if (cnt == CW'(H - 1)) begin
               cnt     <= '0;
               bit_idx <= '0;
               state   <= vote ? IDLE : DATA;
            end
            DATA: if (bit_end) begin
               cnt     <= '0;
               sh      <= {vote, sh[7:1]};
               bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (bit_idx == 3'd7) state <= PARITY;
`else
               if (bit_idx == 3'd7) state <= STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (bit_end) begin
               cnt   <= '0;
               par   <= vote;
               state <= STOP;
            end
`endif
            STOP: if (bit_end) begin
               cnt <= '0;
               if (!vote) begin
                  o_frame_err <= 1'b1;
                  state       <= WAIT_IDLE;
               end else begin
                  state <= IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par != ^sh) o_parity_err <= 1'b1;
                  else if (o_valid && !i_ready) o_overrun <= 1'b1;
`else
                  if (o_valid && !i_ready) o_overrun <= 1'b1;
`endif
                  else begin
                     o_data  <= sh;
                     o_valid <= 1'b1;
                  end
               end
            end
            WAIT_IDLE: if (i_rx) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
